// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline hazard scheduler:
// scheduler FSM states, forwarding-source encodings and register address width.
package pipe_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Per-source bypass selection: picks MEM over WB when both write the register ID reads.
// Register x0 never matches, so a zero source always reads the register file.
module pipe_fwd_sel #(
  parameter int AW = pipe_pkg::REG_AW
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_we,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_we,
  output logic [1:0]    fwd
);
  import pipe_pkg::*;

  always_comb begin
    fwd = FWD_RF;
    if (rs != '0) begin
      if (mem_we && (mem_rd == rs)) begin
        fwd = FWD_MEM;
      end else if (wb_we && (wb_rd == rs)) begin
        fwd = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_sched.sv
// Stall/flush/forward scheduler for the 5-stage RV32I pipeline plus retired-instruction counter.
// Define FORWARDING_EN to enable MEM/WB bypassing; otherwise every RAW hazard stalls.
module pipe_hazard_sched #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] ID_RS1,
  input  logic [REG_AW-1:0] ID_RS2,
  input  logic [1:0]        ID_USE,
  input  logic [REG_AW-1:0] EX_RD,
  input  logic              EX_RF_WE,
  input  logic              EX_IS_LOAD,
  input  logic [REG_AW-1:0] MEM_RD,
  input  logic              MEM_RF_WE,
  input  logic [REG_AW-1:0] WB_RD,
  input  logic              WB_RF_WE,
  input  logic              WB_NUM_CHECK,
  input  logic              EX_REDIRECT,
  input  logic              D_MEM_REQ,
  input  logic              D_MEM_READY,
  output logic              PC_WE,
  output logic              IFID_WE,
  output logic              IFID_FLUSH,
  output logic              IDEX_FLUSH,
  output logic              PIPE_HOLD,
  output logic [1:0]        FWD_A,
  output logic [1:0]        FWD_B,
  output logic [CNT_W-1:0]  RETIRED
);
  import pipe_pkg::*;

`ifdef FORWARDING_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  state_t     state, state_nxt;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       rs1_used, rs2_used;
  logic       ex_hit, ex_stall, raw_stall, stall, mem_hold;

  pipe_fwd_sel #(.AW(REG_AW)) u_fwd_a (
    .rs     (ID_RS1),
    .mem_rd (MEM_RD),
    .mem_we (MEM_RF_WE),
    .wb_rd  (WB_RD),
    .wb_we  (WB_RF_WE),
    .fwd    (fwd_a_sel)
  );

  pipe_fwd_sel #(.AW(REG_AW)) u_fwd_b (
    .rs     (ID_RS2),
    .mem_rd (MEM_RD),
    .mem_we (MEM_RF_WE),
    .wb_rd  (WB_RD),
    .wb_we  (WB_RF_WE),
    .fwd    (fwd_b_sel)
  );

  assign rs1_used = ID_USE[0] && (ID_RS1 != '0);
  assign rs2_used = ID_USE[1] && (ID_RS2 != '0);

  assign ex_hit = EX_RF_WE && (EX_RD != '0) &&
                  ((rs1_used && (EX_RD == ID_RS1)) || (rs2_used && (EX_RD == ID_RS2)));

  // Without bypassing, any producer still in flight (EX, MEM or WB) must stall ID.
  assign ex_stall  = ex_hit && (EX_IS_LOAD || !FWD_ON);
  assign raw_stall = !FWD_ON && ((rs1_used && (fwd_a_sel != FWD_RF)) ||
                                 (rs2_used && (fwd_b_sel != FWD_RF)));
  assign stall     = (ex_stall || raw_stall) && (state != FLUSH);

  // While waiting, the pipe stays frozen until the memory reports completion.
  assign mem_hold = (state == MEM_WAIT) ? !D_MEM_READY : (D_MEM_REQ && !D_MEM_READY);

`ifdef FORWARDING_EN
  assign FWD_A = RST ? FWD_RF : fwd_a_sel;
  assign FWD_B = RST ? FWD_RF : fwd_b_sel;
`else
  assign FWD_A = FWD_RF;
  assign FWD_B = FWD_RF;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = RUN;
    PC_WE      = 1'b1;
    IFID_WE    = 1'b1;
    IFID_FLUSH = 1'b0;
    IDEX_FLUSH = 1'b0;
    PIPE_HOLD  = 1'b0;
    if (mem_hold) begin
      state_nxt = MEM_WAIT;
      PC_WE     = 1'b0;
      IFID_WE   = 1'b0;
      PIPE_HOLD = 1'b1;
    end else if (EX_REDIRECT) begin
      state_nxt  = FLUSH;
      IFID_FLUSH = 1'b1;
      IDEX_FLUSH = 1'b1;
    end else if (stall) begin
      PC_WE      = 1'b0;
      IFID_WE    = 1'b0;
      IDEX_FLUSH = 1'b1;
    end
    // Reset forces the idle output pattern even while a memory request is pending.
    if (RST) begin
      state_nxt  = RUN;
      PC_WE      = 1'b1;
      IFID_WE    = 1'b1;
      IFID_FLUSH = 1'b0;
      IDEX_FLUSH = 1'b0;
      PIPE_HOLD  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RETIRED <= '0;
    end else if (WB_NUM_CHECK && !PIPE_HOLD) begin
      RETIRED <= RETIRED + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Directed self-checking bench for pipe_hazard_sched; expectations follow FORWARDING_EN
// so the same bench covers both build configurations.
module tb_pipe_hazard_sched;

`ifdef FORWARDING_EN
  localparam logic FWD_ON = 1'b1;
`else
  localparam logic FWD_ON = 1'b0;
`endif

  logic        CLK, RST;
  logic [4:0]  ID_RS1, ID_RS2, EX_RD, MEM_RD, WB_RD;
  logic [1:0]  ID_USE;
  logic        EX_RF_WE, EX_IS_LOAD, MEM_RF_WE, WB_RF_WE;
  logic        WB_NUM_CHECK, EX_REDIRECT, D_MEM_REQ, D_MEM_READY;
  logic        PC_WE, IFID_WE, IFID_FLUSH, IDEX_FLUSH, PIPE_HOLD;
  logic [1:0]  FWD_A, FWD_B;
  logic [31:0] RETIRED;

  int testCount = 0;
  int failCount = 0;

  pipe_hazard_sched #(.CNT_W(32), .REG_AW(5)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ID_RS1       (ID_RS1),
    .ID_RS2       (ID_RS2),
    .ID_USE       (ID_USE),
    .EX_RD        (EX_RD),
    .EX_RF_WE     (EX_RF_WE),
    .EX_IS_LOAD   (EX_IS_LOAD),
    .MEM_RD       (MEM_RD),
    .MEM_RF_WE    (MEM_RF_WE),
    .WB_RD        (WB_RD),
    .WB_RF_WE     (WB_RF_WE),
    .WB_NUM_CHECK (WB_NUM_CHECK),
    .EX_REDIRECT  (EX_REDIRECT),
    .D_MEM_REQ    (D_MEM_REQ),
    .D_MEM_READY  (D_MEM_READY),
    .PC_WE        (PC_WE),
    .IFID_WE      (IFID_WE),
    .IFID_FLUSH   (IFID_FLUSH),
    .IDEX_FLUSH   (IDEX_FLUSH),
    .PIPE_HOLD    (PIPE_HOLD),
    .FWD_A        (FWD_A),
    .FWD_B        (FWD_B),
    .RETIRED      (RETIRED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] use_v,
                               input logic [4:0] exRd, input logic exWe, input logic exLoad,
                               input logic [4:0] memRd, input logic memWe,
                               input logic [4:0] wbRd, input logic wbWe);
    ID_RS1 = rs1;   ID_RS2 = rs2;     ID_USE = use_v;
    EX_RD = exRd;   EX_RF_WE = exWe;  EX_IS_LOAD = exLoad;
    MEM_RD = memRd; MEM_RF_WE = memWe;
    WB_RD = wbRd;   WB_RF_WE = wbWe;
    #2;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_pc_we"}, {31'd0, PC_WE}, 32'd1);
    checkOutput({tag, "_ifid_we"}, {31'd0, IFID_WE}, 32'd1);
    checkOutput({tag, "_ifid_flush"}, {31'd0, IFID_FLUSH}, 32'd0);
    checkOutput({tag, "_idex_flush"}, {31'd0, IDEX_FLUSH}, 32'd0);
    checkOutput({tag, "_hold"}, {31'd0, PIPE_HOLD}, 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    WB_NUM_CHECK = 1'b0; EX_REDIRECT = 1'b0; D_MEM_REQ = 1'b0; D_MEM_READY = 1'b0;
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkIdle("reset");
    checkOutput("reset_fwd_a", {30'd0, FWD_A}, 32'd0);
    checkOutput("reset_fwd_b", {30'd0, FWD_B}, 32'd0);
    checkOutput("reset_retired", RETIRED, 32'd0);
    #6 RST = 1'b0;
    tick();

    // lw x5 in EX, add x6,x5,x1 in ID
    applyStimulus(5, 1, 2'b11, 5, 1, 1, 0, 0, 0, 0);
    checkOutput("lu_pc_we", {31'd0, PC_WE}, 32'd0);
    checkOutput("lu_ifid_we", {31'd0, IFID_WE}, 32'd0);
    checkOutput("lu_idex_flush", {31'd0, IDEX_FLUSH}, 32'd1);
    checkOutput("lu_ifid_flush", {31'd0, IFID_FLUSH}, 32'd0);
    tick();
    applyStimulus(5, 1, 2'b11, 0, 0, 0, 5, 1, 0, 0);
    checkOutput("lu_next_fwd_a", {30'd0, FWD_A}, FWD_ON ? 32'd1 : 32'd0);
    checkOutput("lu_next_pc_we", {31'd0, PC_WE}, FWD_ON ? 32'd1 : 32'd0);
    tick();

    // x0 never matches
    applyStimulus(0, 0, 2'b11, 0, 1, 1, 0, 1, 0, 1);
    checkOutput("x0_pc_we", {31'd0, PC_WE}, 32'd1);
    checkOutput("x0_fwd_a", {30'd0, FWD_A}, 32'd0);
    checkOutput("x0_fwd_b", {30'd0, FWD_B}, 32'd0);

    // MEM and WB both write x7: MEM wins
    applyStimulus(0, 7, 2'b11, 0, 1, 1, 7, 1, 7, 1);
    checkOutput("memwb_fwd_b", {30'd0, FWD_B}, FWD_ON ? 32'd1 : 32'd0);
    checkOutput("memwb_fwd_a", {30'd0, FWD_A}, 32'd0);
    checkOutput("memwb_pc_we", {31'd0, PC_WE}, FWD_ON ? 32'd1 : 32'd0);
    applyStimulus(0, 7, 2'b10, 0, 0, 0, 8, 1, 7, 1);
    checkOutput("wb_only_fwd_b", {30'd0, FWD_B}, FWD_ON ? 32'd2 : 32'd0);
    checkOutput("wb_only_pc_we", {31'd0, PC_WE}, FWD_ON ? 32'd1 : 32'd0);
    applyStimulus(0, 7, 2'b00, 0, 0, 0, 7, 0, 7, 1);
    checkOutput("mem_nowe_fwd_b", {30'd0, FWD_B}, FWD_ON ? 32'd2 : 32'd0);
    checkOutput("unused_src_pc_we", {31'd0, PC_WE}, 32'd1);

    // WB writes x3, ID reads x3
    applyStimulus(3, 0, 2'b01, 0, 0, 0, 0, 0, 3, 1);
    checkOutput("wb3_fwd_a", {30'd0, FWD_A}, FWD_ON ? 32'd2 : 32'd0);
    checkOutput("wb3_pc_we", {31'd0, PC_WE}, FWD_ON ? 32'd1 : 32'd0);
    checkOutput("wb3_idex_flush", {31'd0, IDEX_FLUSH}, FWD_ON ? 32'd0 : 32'd1);
    tick();
    applyStimulus(3, 0, 2'b01, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("wb3_after_pc_we", {31'd0, PC_WE}, 32'd1);
    tick();

    // redirect beats load-use, then FLUSH masks the stall for one cycle
    EX_REDIRECT = 1'b1;
    applyStimulus(5, 0, 2'b01, 5, 1, 1, 0, 0, 0, 0);
    checkOutput("redir_ifid_flush", {31'd0, IFID_FLUSH}, 32'd1);
    checkOutput("redir_idex_flush", {31'd0, IDEX_FLUSH}, 32'd1);
    checkOutput("redir_pc_we", {31'd0, PC_WE}, 32'd1);
    tick();
    EX_REDIRECT = 1'b0;
    #2;
    checkOutput("flush_pc_we", {31'd0, PC_WE}, 32'd1);
    checkOutput("flush_idex_flush", {31'd0, IDEX_FLUSH}, 32'd0);
    tick();
    checkOutput("post_flush_pc_we", {31'd0, PC_WE}, 32'd0);
    checkOutput("post_flush_idex_flush", {31'd0, IDEX_FLUSH}, 32'd1);
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // D-memory busy for three cycles while WB retires
    WB_NUM_CHECK = 1'b1; D_MEM_REQ = 1'b1; D_MEM_READY = 1'b0;
    #2;
    checkOutput("mw0_hold", {31'd0, PIPE_HOLD}, 32'd1);
    checkOutput("mw0_pc_we", {31'd0, PC_WE}, 32'd0);
    tick();
    EX_REDIRECT = 1'b1;
    #2;
    checkOutput("mw1_hold", {31'd0, PIPE_HOLD}, 32'd1);
    checkOutput("mw1_ifid_flush", {31'd0, IFID_FLUSH}, 32'd0);
    checkOutput("mw1_retired", RETIRED, 32'd0);
    tick();
    EX_REDIRECT = 1'b0;
    #2;
    checkOutput("mw2_hold", {31'd0, PIPE_HOLD}, 32'd1);
    checkOutput("mw2_retired", RETIRED, 32'd0);
    tick();
    D_MEM_READY = 1'b1;
    #2;
    checkOutput("mw_ready_hold", {31'd0, PIPE_HOLD}, 32'd0);
    checkOutput("mw_ready_pc_we", {31'd0, PC_WE}, 32'd1);
    tick();
    WB_NUM_CHECK = 1'b0; D_MEM_REQ = 1'b0; D_MEM_READY = 1'b0;
    #2;
    checkOutput("mw_done_retired", RETIRED, 32'd1);
    checkOutput("mw_done_hold", {31'd0, PIPE_HOLD}, 32'd0);

    // asynchronous reset while in MEM_WAIT
    D_MEM_REQ = 1'b1;
    tick();
    #2;
    checkOutput("rst_pre_hold", {31'd0, PIPE_HOLD}, 32'd1);
    RST = 1'b1;
    #1;
    checkIdle("rst_mid");
    checkOutput("rst_mid_retired", RETIRED, 32'd0);
    D_MEM_REQ = 1'b0;
    RST = 1'b0;
    #1;
    checkOutput("rst_back_run_hold", {31'd0, PIPE_HOLD}, 32'd0);
    tick();

    // ten retire pulses
    WB_NUM_CHECK = 1'b1;
    repeat (10) tick();
    WB_NUM_CHECK = 1'b0;
    #1;
    checkOutput("retired_ten", RETIRED, 32'd10);
    tick();
    checkOutput("retired_stays", RETIRED, 32'd10);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
